// File: rtl/muldiv_unit_pkg.sv
// rtl/muldiv_unit_pkg.sv - shared types and helpers for the muldiv unit
package muldiv_unit_pkg;

  // Operation codes in RV32M funct3 order
  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } muldiv_state_t;

  function automatic logic is_div(input muldiv_op_t op);
    return op[2];
  endfunction

  // rs1 is treated as signed for MULH, MULHSU, DIV, REM
  function automatic logic op_signed_a(input muldiv_op_t op);
    return (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
  endfunction

  // rs2 is treated as signed for MULH, DIV, REM
  function automatic logic op_signed_b(input muldiv_op_t op);
    return (op == MULH) || (op == DIV) || (op == REM);
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - request/response handshake bundle for the muldiv unit
interface muldiv_unit_if
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             req_valid;
  logic             req_ready;
  muldiv_op_t       req_op;
  logic [XLEN-1:0]  req_a;
  logic [XLEN-1:0]  req_b;
  logic [TAG_W-1:0] req_tag;
  logic             resp_valid;
  logic             resp_ready;
  logic [XLEN-1:0]  resp_data;
  logic [TAG_W-1:0] resp_tag;

  modport master (
    output req_valid, req_op, req_a, req_b, req_tag, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_tag
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_tag, resp_ready,
    output req_ready, resp_valid, resp_data, resp_tag
  );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative radix-2 RV32M multiply/divide unit with tag passthrough
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  muldiv_unit_if.slave  bus,
  output logic          busy
);
  import muldiv_unit_pkg::*;

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t      state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  muldiv_op_t         op_q, op_d;
  logic [XLEN-1:0]    opb_q, opb_d;        // |multiplicand| or |divisor|
  logic [2*XLEN-1:0]  acc_q, acc_d;        // product, or {remainder, quotient}
  logic               neg_q, neg_d;        // negate product / quotient in FIX
  logic               rneg_q, rneg_d;      // negate remainder in FIX
  logic [TAG_W-1:0]   tag_hold_q, tag_hold_d;
  logic [XLEN-1:0]    data_q, data_d;
  logic [TAG_W-1:0]   rtag_q, rtag_d;

  logic               sa, sb;
  logic [XLEN-1:0]    abs_a, abs_b;
  logic [XLEN:0]      mul_sum;
  logic [XLEN:0]      div_shift;
  logic               div_ge;
  logic [XLEN-1:0]    div_rem;
  logic [2*XLEN-1:0]  prod_fix;
  logic [XLEN-1:0]    quo_fix, rem_fix;
  logic [XLEN-1:0]    result;

  // State and datapath registers; flush only steers the state back to IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_q       <= MUL;
      opb_q      <= '0;
      acc_q      <= '0;
      neg_q      <= 1'b0;
      rneg_q     <= 1'b0;
      tag_hold_q <= '0;
      data_q     <= '0;
      rtag_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      opb_q      <= opb_d;
      acc_q      <= acc_d;
      neg_q      <= neg_d;
      rneg_q     <= rneg_d;
      tag_hold_q <= tag_hold_d;
      data_q     <= data_d;
      rtag_q     <= rtag_d;
    end
  end

  // Next-state, iteration step and result fix-up
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    opb_d      = opb_q;
    acc_d      = acc_q;
    neg_d      = neg_q;
    rneg_d     = rneg_q;
    tag_hold_d = tag_hold_q;
    data_d     = data_q;
    rtag_d     = rtag_q;

    // Operand magnitudes; |MIN| wraps to 2^(XLEN-1), which is correct as unsigned
    sa    = op_signed_a(bus.req_op) & bus.req_a[XLEN-1];
    sb    = op_signed_b(bus.req_op) & bus.req_b[XLEN-1];
    abs_a = sa ? -bus.req_a : bus.req_a;
    abs_b = sb ? -bus.req_b : bus.req_b;

    // Shift-add: add multiplicand into the upper half when the low bit is set
    mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);

    // Restoring divide: shift in next dividend bit, subtract if it fits
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_ge    = div_shift >= {1'b0, opb_q};
    div_rem   = div_ge ? (div_shift[XLEN-1:0] - opb_q) : div_shift[XLEN-1:0];

    prod_fix = neg_q ? -acc_q : acc_q;
    quo_fix  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix  = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

    case (op_q)
      MULH, MULHSU, MULHU: result = prod_fix[2*XLEN-1:XLEN];
      DIV, DIVU:           result = quo_fix;
      REM, REMU:           result = rem_fix;
      default:             result = prod_fix[XLEN-1:0];
    endcase

    case (state_q)
      IDLE: begin
        if (bus.req_valid && !flush) begin
          if (is_div(bus.req_op) && (bus.req_b == '0)) begin
            data_d  = bus.req_op[1] ? bus.req_a : '1;
            rtag_d  = bus.req_tag;
            state_d = DONE;
          end else if (is_div(bus.req_op) && !bus.req_op[0] &&
                       (bus.req_a == MIN_VAL) && (bus.req_b == '1)) begin
            data_d  = bus.req_op[1] ? '0 : MIN_VAL;
            rtag_d  = bus.req_tag;
            state_d = DONE;
          end else begin
            op_d       = bus.req_op;
            opb_d      = abs_b;
            acc_d      = {{XLEN{1'b0}}, abs_a};
            neg_d      = sa ^ sb;
            rneg_d     = sa;
            tag_hold_d = bus.req_tag;
            cnt_d      = CNT_W'(XLEN - 1);
            state_d    = CALC;
          end
        end
      end
      CALC: begin
        if (is_div(op_q)) begin
          acc_d = {div_rem, acc_q[XLEN-2:0], div_ge};
        end else begin
          acc_d = {mul_sum, acc_q[XLEN-1:1]};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = FIX;
        end
      end
      FIX: begin
        data_d  = result;
        rtag_d  = tag_hold_q;
        state_d = DONE;
      end
      DONE: begin
        if (bus.resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d = IDLE;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == DONE);
  assign bus.resp_data  = data_q;
  assign bus.resp_tag   = rtag_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;
  localparam logic [31:0] MINV = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic busy;

  int total = 0;
  int bad   = 0;

  muldiv_unit_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

  muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus.slave),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    muldiv_op_t  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs [14] = '{
    '{MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 34},
    '{MULH,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34},
    '{MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34},
    '{MULHU,  32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 34},
    '{DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34},
    '{REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34},
    '{DIVU,   32'd100,       32'd7,         32'd14,        34},
    '{REMU,   32'd100,       32'd7,         32'd2,         34},
    '{DIV,    32'd1234,      32'd0,         32'hFFFF_FFFF, 1},
    '{REM,    32'd5,         32'd0,         32'd5,         1},
    '{DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1},
    '{REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1},
    '{DIVU,   32'd77,        32'd0,         32'hFFFF_FFFF, 1},
    '{REMU,   32'd9,         32'd0,         32'd9,         1}
  };

  // Reference result from the RV32M arithmetic rules using 64-bit integers
  function automatic logic [31:0] ref_result(input muldiv_op_t op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'b0, a});
    longint ub = longint'({32'b0, b});
    logic [63:0] p;
    case (op)
      MUL:    begin p = ua * ub; return p[31:0];  end
      MULH:   begin p = sa * sb; return p[63:32]; end
      MULHSU: begin p = sa * ub; return p[63:32]; end
      MULHU:  begin p = ua * ub; return p[63:32]; end
      DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == MINV && b == 32'hFFFF_FFFF) return MINV;
        p = sa / sb; return p[31:0];
      end
      DIVU: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      REM: begin
        if (b == 32'd0) return a;
        if (a == MINV && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int ref_latency(input muldiv_op_t op, input logic [31:0] a,
                                     input logic [31:0] b);
    if ((op == DIV || op == DIVU || op == REM || op == REMU) && b == 32'd0) return 1;
    if ((op == DIV || op == REM) && a == MINV && b == 32'hFFFF_FFFF) return 1;
    return XLEN + 2;
  endfunction

  // Issue one request, wait (bounded) for resp_valid; drains if resp_ready is high
  task automatic run_op(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, output logic [31:0] data,
                        output logic [4:0] rtag, output int lat);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_tag   = tag;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (bus.resp_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    data = bus.resp_data;
    rtag = bus.resp_tag;
    if (bus.resp_ready && bus.resp_valid) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b want=1", bus.req_ready); end
    total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%b want=0", bus.resp_valid); end
    total++; if (bus.resp_data !== 32'd0) begin bad++; $display("FAIL reset_resp_data got=%h want=0", bus.resp_data); end
    total++; if (bus.resp_tag !== 5'd0) begin bad++; $display("FAIL reset_resp_tag got=%h want=0", bus.resp_tag); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] d;
    logic [4:0]  t;
    int          lat;
    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 3), d, t, lat);
      total++; if (d !== vecs[i].exp) begin bad++; $display("FAIL directed_data[%0d] got=%h want=%h", i, d, vecs[i].exp); end
      total++; if (t !== 5'(i + 3)) begin bad++; $display("FAIL directed_tag[%0d] got=%h want=%h", i, t, 5'(i + 3)); end
      total++; if (lat != vecs[i].lat) begin bad++; $display("FAIL directed_latency[%0d] got=%0d want=%0d", i, lat, vecs[i].lat); end
      total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL directed_idle[%0d] got=%b want=1", i, bus.req_ready); end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, d;
    logic [4:0]  tag, t;
    muldiv_op_t  op;
    int          lat, sel;
    for (int i = 0; i < 80; i++) begin
      op  = muldiv_op_t'($urandom_range(0, 7));
      a   = $urandom;
      b   = $urandom;
      tag = 5'($urandom);
      sel = $urandom_range(0, 9);
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = MINV; b = 32'hFFFF_FFFF; end
      else if (sel == 2) b = 32'($urandom_range(1, 15));
      else if (sel == 3) a = MINV;
      run_op(op, a, b, tag, d, t, lat);
      total++; if (d !== ref_result(op, a, b)) begin bad++; $display("FAIL random_data op=%0d a=%h b=%h got=%h want=%h", op, a, b, d, ref_result(op, a, b)); end
      total++; if (t !== tag) begin bad++; $display("FAIL random_tag got=%h want=%h", t, tag); end
      total++; if (lat != ref_latency(op, a, b)) begin bad++; $display("FAIL random_latency op=%0d got=%0d want=%0d", op, lat, ref_latency(op, a, b)); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d;
    logic [4:0]  t;
    int          lat;
    bus.resp_ready = 1'b0;
    run_op(MULHU, 32'hDEAD_BEEF, 32'h1234_5678, 5'd21, d, t, lat);
    total++; if (d !== ref_result(MULHU, 32'hDEAD_BEEF, 32'h1234_5678)) begin bad++; $display("FAIL bp_data got=%h want=%h", d, ref_result(MULHU, 32'hDEAD_BEEF, 32'h1234_5678)); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      total++;
      if (bus.resp_valid !== 1'b1 || bus.resp_data !== d || bus.resp_tag !== 5'd21 || bus.req_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold[%0d] valid=%b data=%h tag=%h req_ready=%b want 1/%h/15/0", i, bus.resp_valid, bus.resp_data, bus.resp_tag, bus.req_ready, d);
      end
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL bp_release valid=%b req_ready=%b busy=%b want 0/1/0", bus.resp_valid, bus.req_ready, busy); end
  endtask

  task automatic test_flush();
    logic [31:0] d;
    logic [4:0]  t;
    int          lat, seen;
    // flush mid-CALC of a DIV
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = DIV; bus.req_a = 32'd1000; bus.req_b = 32'd3; bus.req_tag = 5'd9;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    total++; if (busy !== 1'b0 || bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin bad++; $display("FAIL flush_calc busy=%b req_ready=%b valid=%b want 0/1/0", busy, bus.req_ready, bus.resp_valid); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.resp_valid === 1'b1) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL flush_no_resp got=%0d want=0", seen); end
    // flush while a result waits in DONE
    bus.resp_ready = 1'b0;
    run_op(DIV, 32'd1, 32'd0, 5'd4, d, t, lat);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    bus.resp_ready = 1'b1;
    total++; if (bus.resp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL flush_done valid=%b busy=%b want 0/0", bus.resp_valid, busy); end
    // flush together with a request: not accepted
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = MUL; bus.req_a = 32'd3; bus.req_b = 32'd4; bus.req_tag = 5'd1;
    flush = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    flush = 1'b0;
    total++; if (busy !== 1'b0 || bus.resp_valid !== 1'b0) begin bad++; $display("FAIL flush_req busy=%b valid=%b want 0/0", busy, bus.resp_valid); end
    // unit still works after flushes
    run_op(REM, 32'hFFFF_FF9C, 32'd7, 5'd30, d, t, lat);
    total++; if (d !== 32'hFFFF_FFFE || t !== 5'd30) begin bad++; $display("FAIL flush_recover data=%h tag=%h want fffffffe/1e", d, t); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = MULH; bus.req_a = 32'h1234_5678; bus.req_b = 32'h9ABC_DEF0; bus.req_tag = 5'd17;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rstmid_ctrl req_ready=%b valid=%b busy=%b want 1/0/0", bus.req_ready, bus.resp_valid, busy); end
    total++; if (bus.resp_data !== 32'd0 || bus.resp_tag !== 5'd0) begin bad++; $display("FAIL rstmid_data data=%h tag=%h want 0/0", bus.resp_data, bus.resp_tag); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    flush          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_op     = MUL;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.req_tag    = '0;
    bus.resp_ready = 1'b1;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
